// File: rtl/mem_sp_param_if.sv
// mem_sp_param_if
//  Request/response bus for the parametrised single-port RAM.
//  master: drives req_valid/req_we/req_addr/req_wdata, sees req_ready and rsp_*.
//  slave : the memory side; drives req_ready and the rsp_* pulses/data.
//  Parameters DATA_W and DEPTH must match the attached mem_sp_param instance.
interface mem_sp_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_perr;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_perr
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_perr
  );
endinterface

// File: rtl/mem_sp_param.sv
// mem_sp_param
//  Parametrised single-port synchronous RAM with a valid/ready request port,
//  a registered (latency 1) read response and a zero-sweep FSM that clears
//  every word after reset or when 'clear' is pulsed while idle.
// Parameters
//  DATA_W : word width in bits
//  DEPTH  : number of words (need not be a power of two)
// Ports
//  clk    : clock, all state updates on posedge
//  rst_n  : asynchronous active-low reset
//  clear  : one-cycle pulse, restarts the zero sweep (honoured only in IDLE)
//  busy   : high while the zero sweep is running
//  bus    : mem_sp_param_if.slave request/response bus
// Configuration
//  MEM_PARITY_EN : when defined, every word carries an even-parity bit that is
//                  checked on read and reported on rsp_perr; otherwise rsp_perr=0.
module mem_sp_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic busy,
  mem_sp_param_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] ptr, next_ptr;
  logic              accept;
  logic              in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  // One extra bit on the compare so a non-power-of-two DEPTH is checked exactly.
  assign in_range = ({1'b0, bus.req_addr} < DEPTH_V);

  // State and sweep pointer; reset always restarts the sweep from word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
    end
  end

  // Next state, handshake and the single memory write port. A clear in IDLE
  // drops req_ready in the same cycle, so a coincident request is never taken.
  always_comb begin
    next_state    = state;
    next_ptr      = ptr;
    busy          = 1'b0;
    bus.req_ready = 1'b0;
    accept        = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = ptr;
    mem_wdata     = '0;
    case (state)
      ST_CLEAR: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        if (ptr == LAST_PTR) begin
          next_state = ST_IDLE;
          next_ptr   = '0;
        end else begin
          next_ptr = ptr + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear) begin
          next_state = ST_CLEAR;
          next_ptr   = '0;
        end else begin
          bus.req_ready = 1'b1;
          accept        = bus.req_valid;
          if (accept && bus.req_we && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = bus.req_addr;
            mem_wdata = bus.req_wdata;
          end
        end
      end
      default: next_state = ST_CLEAR;
    endcase
  end

`ifdef MEM_PARITY_EN
  logic par_mem [DEPTH];
`endif

  // Storage is not reset; the sweep is what brings it to a known state.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
`ifdef MEM_PARITY_EN
      par_mem[mem_waddr] <= ^mem_wdata;
`endif
    end
  end

  // Response registers: out-of-range reads return zero data with rsp_err, and
  // out-of-range writes raise rsp_err alone. rsp_rdata holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= accept && !bus.req_we;
      bus.rsp_err   <= accept && !in_range;
      if (accept && !bus.req_we) begin
        bus.rsp_rdata <= in_range ? mem[bus.req_addr] : '0;
      end
    end
  end

`ifdef MEM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_perr <= 1'b0;
    end else begin
      bus.rsp_perr <= accept && !bus.req_we && in_range &&
                      (par_mem[bus.req_addr] != ^mem[bus.req_addr]);
    end
  end
`else
  assign bus.rsp_perr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_sp_param.sv
// tb_mem_sp_param
//  Self-checking bench for mem_sp_param. Two instances share clock and reset:
//  dut (DATA_W=8, DEPTH=4) and dut3 (DATA_W=8, DEPTH=3, for out-of-range
//  addresses). Inputs change on the falling edge; outputs are sampled there.
//  Build with MEM_PARITY_EN defined to exercise the parity path.
module tb_mem_sp_param;

  logic clk = 1'b0;
  logic rst_n;
  logic clear4, clear3;
  logic busy4, busy3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_sp_param_if #(.DATA_W(8), .DEPTH(4)) bus4 ();
  mem_sp_param_if #(.DATA_W(8), .DEPTH(3)) bus3 ();

  mem_sp_param #(.DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear4), .busy(busy4), .bus(bus4)
  );

  mem_sp_param #(.DATA_W(8), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .clear(clear3), .busy(busy3), .bus(bus3)
  );

  // One request per row; sel picks dut (0) or dut3 (1).
  typedef struct {
    bit         sel;
    bit         we;
    logic [1:0] addr;
    logic [7:0] wdata;
    bit         exp_valid;
    logic [7:0] exp_rdata;
    bit         exp_err;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input bit sel, input bit we, input logic [1:0] addr,
                              input logic [7:0] wdata, input bit ev,
                              input logic [7:0] er, input bit ee);
    vec_t v;
    v.sel = sel; v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_valid = ev; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input bit sel, input bit valid, input bit we,
                                input logic [1:0] addr, input logic [7:0] wdata);
    bus4.req_valid = valid && !sel;
    bus4.req_we    = we;
    bus4.req_addr  = addr;
    bus4.req_wdata = wdata;
    bus3.req_valid = valid && sel;
    bus3.req_we    = we;
    bus3.req_addr  = addr;
    bus3.req_wdata = wdata;
  endtask

  task automatic check_rsp(input string name, input bit sel, input bit ev,
                           input logic [7:0] er, input bit ee, input bit ep);
    if (sel) begin
      check_output({name, ".valid"}, 32'(bus3.rsp_valid), 32'(ev));
      check_output({name, ".rdata"}, 32'(bus3.rsp_rdata), 32'(er));
      check_output({name, ".err"},   32'(bus3.rsp_err),   32'(ee));
      check_output({name, ".perr"},  32'(bus3.rsp_perr),  32'(ep));
    end else begin
      check_output({name, ".valid"}, 32'(bus4.rsp_valid), 32'(ev));
      check_output({name, ".rdata"}, 32'(bus4.rsp_rdata), 32'(er));
      check_output({name, ".err"},   32'(bus4.rsp_err),   32'(ee));
      check_output({name, ".perr"},  32'(bus4.rsp_perr),  32'(ep));
    end
  endtask

  // Called on the falling edge where the sweep starts: dut must stay busy for
  // four sampled cycles, dut3 for three, then both report ready.
  task automatic sweep_check(input string name, input bit with3);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("%s.busy[%0d]", name, i), 32'(busy4), 32'd1);
      check_output($sformatf("%s.ready[%0d]", name, i), 32'(bus4.req_ready), 32'd0);
      if (with3)
        check_output($sformatf("%s.busy3[%0d]", name, i), 32'(busy3), 32'(i < 3));
      @(negedge clk);
    end
    check_output({name, ".busy_end"}, 32'(busy4), 32'd0);
    check_output({name, ".ready_end"}, 32'(bus4.req_ready), 32'd1);
  endtask

  // Back-to-back reads of dut words 0..3; rsp_valid must be high four cycles.
  task automatic read_burst(input string name, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_q [4];
    exp_q[0] = e0; exp_q[1] = e1; exp_q[2] = e2; exp_q[3] = e3;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 2'(i), 8'h00);
      @(negedge clk);
      check_rsp($sformatf("%s[%0d]", name, i), 1'b0, 1'b1, exp_q[i], 1'b0, 1'b0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    check_output({name, ".valid_after"}, 32'(bus4.rsp_valid), 32'd0);
  endtask

  task automatic write_word(input bit sel, input logic [1:0] addr, input logic [7:0] data);
    apply_stimulus(sel, 1'b1, 1'b1, addr, data);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  initial begin
    rst_n  = 1'b0;
    clear4 = 1'b0;
    clear3 = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);

    // Table: dut rows 0..9, dut3 rows 10..18 (out-of-range address 3).
    tbl[0]  = mk(0, 0, 2'd0, 8'h00, 1, 8'h00, 0);
    tbl[1]  = mk(0, 0, 2'd3, 8'h00, 1, 8'h00, 0);
    tbl[2]  = mk(0, 1, 2'd3, 8'h94, 0, 8'h00, 0);
    tbl[3]  = mk(0, 0, 2'd3, 8'h00, 1, 8'h94, 0);
    tbl[4]  = mk(0, 1, 2'd0, 8'hA5, 0, 8'h94, 0);
    tbl[5]  = mk(0, 0, 2'd0, 8'h00, 1, 8'hA5, 0);
    tbl[6]  = mk(0, 1, 2'd1, 8'hF0, 0, 8'hA5, 0);
    tbl[7]  = mk(0, 0, 2'd1, 8'h00, 1, 8'hF0, 0);
    tbl[8]  = mk(0, 0, 2'd2, 8'h00, 1, 8'h00, 0);
    tbl[9]  = mk(0, 0, 2'd3, 8'h00, 1, 8'h94, 0);
    tbl[10] = mk(1, 1, 2'd0, 8'hAA, 0, 8'h00, 0);
    tbl[11] = mk(1, 1, 2'd1, 8'hBB, 0, 8'h00, 0);
    tbl[12] = mk(1, 1, 2'd2, 8'hCC, 0, 8'h00, 0);
    tbl[13] = mk(1, 1, 2'd3, 8'hFF, 0, 8'h00, 1);
    tbl[14] = mk(1, 0, 2'd3, 8'h00, 1, 8'h00, 1);
    tbl[15] = mk(1, 0, 2'd0, 8'h00, 1, 8'hAA, 0);
    tbl[16] = mk(1, 0, 2'd1, 8'h00, 1, 8'hBB, 0);
    tbl[17] = mk(1, 0, 2'd2, 8'h00, 1, 8'hCC, 0);
    tbl[18] = mk(1, 0, 2'd3, 8'h00, 1, 8'h00, 1);

    repeat (2) @(negedge clk);
    check_output("reset.busy", 32'(busy4), 32'd1);
    check_output("reset.ready", 32'(bus4.req_ready), 32'd0);
    check_rsp("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    rst_n = 1'b1;
    sweep_check("sweep0", 1'b1);
    read_burst("zero_rd", 8'h00, 8'h00, 8'h00, 8'h00);

    $display("[TB] table vectors");
    for (int i = 0; i < 19; i++) begin
      apply_stimulus(tbl[i].sel, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      @(negedge clk);
      check_rsp($sformatf("vec%0d", i), tbl[i].sel, tbl[i].exp_valid,
                tbl[i].exp_rdata, tbl[i].exp_err, 1'b0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);

    $display("[TB] back-to-back reads");
    write_word(1'b0, 2'd0, 8'h11);
    write_word(1'b0, 2'd1, 8'h22);
    write_word(1'b0, 2'd2, 8'h33);
    write_word(1'b0, 2'd3, 8'h44);
    read_burst("b2b", 8'h11, 8'h22, 8'h33, 8'h44);

    $display("[TB] clear pulse");
    write_word(1'b0, 2'd1, 8'hF0);
    clear4 = 1'b1;
    apply_stimulus(1'b0, 1'b1, 1'b1, 2'd1, 8'h77);
    #1;
    check_output("clear.ready_drop", 32'(bus4.req_ready), 32'd0);
    @(negedge clk);
    clear4 = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    fork
      begin
        // A clear mid-sweep must not extend it.
        @(negedge clk);
        clear4 = 1'b1;
        @(negedge clk);
        clear4 = 1'b0;
      end
      sweep_check("clear_sweep", 1'b0);
    join
    read_burst("after_clear", 8'h00, 8'h00, 8'h00, 8'h00);

    $display("[TB] parity");
    write_word(1'b0, 2'd2, 8'h01);
    apply_stimulus(1'b0, 1'b1, 1'b0, 2'd2, 8'h00);
    @(negedge clk);
    check_rsp("par_ok", 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
`ifdef MEM_PARITY_EN
    dut.par_mem[2] = ~dut.par_mem[2];
    @(negedge clk);
    check_rsp("par_bad", 1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
`else
    @(negedge clk);
    check_rsp("par_off", 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
`endif
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);

    $display("[TB] reset mid-read and mid-sweep");
    write_word(1'b0, 2'd2, 8'h5A);
    apply_stimulus(1'b0, 1'b1, 1'b0, 2'd2, 8'h00);
    @(posedge clk);
    #1;
    check_rsp("pre_reset", 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_rsp("mid_read_reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_output("mid_read_reset.busy", 32'(busy4), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sweep_check("sweep_restart", 1'b1);
    read_burst("after_reset", 8'h00, 8'h00, 8'h00, 8'h00);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
